// File: rtl/moore_pkg.sv
// Shared definitions for the moore_seq_det serial pattern detector.
//   - y status encodings (idle / partial / near / match)
//   - hit counter width
//   - kmp_next: KMP-style fallback used to build the next-state table
//   - y_status: maps a match depth onto the 2-bit status code
package moore_pkg;

  localparam logic [1:0] YIdle    = 2'b00;
  localparam logic [1:0] YPartial = 2'b01;
  localparam logic [1:0] YNear    = 2'b10;
  localparam logic [1:0] YMatch   = 2'b11;

  localparam int unsigned HitCntW = 8;

  // Longest prefix of the pattern that is a suffix of (first s pattern bits, xb).
  // pat holds the pattern right-aligned; its bit len-1 is the first expected bit.
  // A full match with overlap disabled restarts from an empty history.
  function automatic int unsigned kmp_next(int unsigned len, logic [7:0] pat, bit overlap,
                                           int unsigned s, logic xb);
    int          s_eff;
    int          best;
    int          m;
    logic        ok;
    logic        cb;
    logic        pb;
    logic [7:0]  tmp;
    s_eff = (s >= len && !overlap) ? 0 : int'(s);
    best  = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= int'(len) && k <= s_eff + 1) begin
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (i < k) begin
            m   = s_eff + 1 - k + i;
            tmp = pat >> (int'(len) - 1 - m);
            cb  = (m == s_eff) ? xb : tmp[0];
            tmp = pat >> (int'(len) - 1 - i);
            pb  = tmp[0];
            if (cb != pb) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return int'(best);
  endfunction

  function automatic logic [1:0] y_status(int unsigned s, int unsigned len);
    logic [1:0] y;
    if (s == 0)             y = YIdle;
    else if (s >= len)      y = YMatch;
    else if (s == len - 1)  y = YNear;
    else                    y = YPartial;
    return y;
  endfunction

endpackage

// File: rtl/moore_seq_next.sv
// Combinational next-state function of the sequence detector.
// Ports:
//   cur  - current match depth (0..LEN)
//   x    - incoming serial bit
//   nxt  - match depth after consuming x (KMP fallback, overlap per OVERLAP)
// The whole transition table is a function of parameters only, so it is built
// at elaboration time and reduces to a small mux on (cur, x).
module moore_seq_next
  import moore_pkg::*;
#(
  parameter int unsigned      LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  localparam int unsigned     SW      = $clog2(LEN + 1)
) (
  input  logic [SW-1:0] cur,
  input  logic          x,
  output logic [SW-1:0] nxt
);

  localparam logic [SW-1:0] SMax = SW'(LEN);

  logic [SW-1:0] tbl [LEN+1][2];

  for (genvar gs = 0; gs <= LEN; gs++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      assign tbl[gs][gb] = SW'(kmp_next(LEN, 8'(PATTERN), OVERLAP, gs, 1'(gb)));
    end
  end

  // Unreachable encodings above LEN fall back to the idle state.
  assign nxt = (cur <= SMax) ? tbl[cur][x] : '0;

endmodule

// File: rtl/moore_seq_det.sv
// Moore-style serial pattern detector with KMP fallback on mismatch.
// Optional feature: define MOORE_SEQ_DET_CNT_EN to add the saturating hit_cnt output.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   x        - serial data bit
//   x_valid  - x is consumed only when high
//   y        - status: 00 idle, 01 partial, 10 near, 11 match (registered)
//   match    - high while the full pattern is matched (registered)
//   progress - number of pattern bits currently matched
//   hit_cnt  - saturating count of entries into the match state (optional)
module moore_seq_det
  import moore_pkg::*;
#(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x,
  input  logic                       x_valid,
  output logic [1:0]                 y,
  output logic                       match,
  output logic [$clog2(LEN+1)-1:0]   progress
`ifdef MOORE_SEQ_DET_CNT_EN
  ,
  output logic [HitCntW-1:0]         hit_cnt
`endif
);

  localparam int unsigned   SW   = $clog2(LEN + 1);
  localparam logic [SW-1:0] SMax = SW'(LEN);

  logic [SW-1:0] state_q, state_d;
  logic [1:0]    y_q;
  logic          match_q;

  moore_seq_next #(
    .LEN     (LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_next (
    .cur (state_q),
    .x   (x),
    .nxt (state_d)
  );

  // Outputs are decoded from the next state and registered with it, so they
  // always describe the state currently held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      y_q     <= YIdle;
      match_q <= 1'b0;
    end else if (x_valid) begin
      state_q <= state_d;
      y_q     <= y_status(32'(state_d), LEN);
      match_q <= (state_d == SMax);
    end
  end

`ifdef MOORE_SEQ_DET_CNT_EN
  logic [HitCntW-1:0] hit_cnt_q;

  // Every consumed bit that lands in the match state counts, including
  // match->match under overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (x_valid && (state_d == SMax) && (hit_cnt_q != '1)) begin
      hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign hit_cnt = hit_cnt_q;
`endif

  assign y        = y_q;
  assign match    = match_q;
  assign progress = state_q;

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed bench for moore_seq_det: three instances (1011 overlap, 1011
// non-overlap, 11 overlap) share one input stream.
module tb_moore_seq_det;

  logic clk = 1'b0;
  logic rst;
  logic x;
  logic x_valid;

  logic [1:0] y_ov, y_no, y_l2;
  logic       m_ov, m_no, m_l2;
  logic [2:0] p_ov, p_no;
  logic [1:0] p_l2;
`ifdef MOORE_SEQ_DET_CNT_EN
  logic [7:0] h_ov, h_no, h_l2;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  moore_seq_det #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .y(y_ov), .match(m_ov), .progress(p_ov)
`ifdef MOORE_SEQ_DET_CNT_EN
    , .hit_cnt(h_ov)
`endif
  );

  moore_seq_det #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_no (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .y(y_no), .match(m_no), .progress(p_no)
`ifdef MOORE_SEQ_DET_CNT_EN
    , .hit_cnt(h_no)
`endif
  );

  moore_seq_det #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) u_l2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .y(y_l2), .match(m_l2), .progress(p_l2)
`ifdef MOORE_SEQ_DET_CNT_EN
    , .hit_cnt(h_l2)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic xb, input logic v);
    x       = xb;
    x_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Stream 1,0,1,1,0,1,1 (first bit at index 6)
  logic [6:0] s7;
  int exp_p_ov[7] = '{1, 2, 3, 4, 2, 3, 4};
  int exp_y_ov[7] = '{1, 1, 2, 3, 1, 2, 3};
  int exp_p_no[7] = '{1, 2, 3, 4, 0, 1, 1};
  int exp_m_no[7] = '{0, 0, 0, 1, 0, 0, 0};
  int exp_y_l2[4] = '{2, 3, 3, 0};
  logic [3:0] s4;

  initial begin
    rst     = 1'b1;
    x       = 1'b0;
    x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", 32'(y_ov), 0);
    check("rst_match", 32'(m_ov), 0);
    check("rst_prog", 32'(p_ov), 0);
    rst = 1'b0;

    // Overlap vs non-overlap on the same stream
    do_reset();
    s7 = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      step(s7[6-i], 1'b1);
      check($sformatf("ov_prog%0d", i + 1), 32'(p_ov), exp_p_ov[i]);
      check($sformatf("ov_y%0d", i + 1), 32'(y_ov), exp_y_ov[i]);
      check($sformatf("ov_match%0d", i + 1), 32'(m_ov), (exp_p_ov[i] == 4) ? 1 : 0);
      check($sformatf("no_prog%0d", i + 1), 32'(p_no), exp_p_no[i]);
      check($sformatf("no_match%0d", i + 1), 32'(m_no), exp_m_no[i]);
    end
`ifdef MOORE_SEQ_DET_CNT_EN
    check("ov_hits", 32'(h_ov), 2);
    check("no_hits", 32'(h_no), 1);
`endif
    // Match state persists while input is idle
    for (int i = 0; i < 3; i++) begin
      step(1'(i), 1'b0);
      check("ov_match_hold", 32'(m_ov), 1);
    end

    // Idle input freezes a partial match
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'(i), 1'b0);
      check("hold_prog", 32'(p_ov), 3);
      check("hold_y", 32'(y_ov), 2);
    end

    // Reset mid-sequence wins over a valid bit
    rst     = 1'b1;
    x       = 1'b1;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_y", 32'(y_ov), 0);
    check("midrst_prog", 32'(p_ov), 0);
    check("midrst_match", 32'(m_ov), 0);
`ifdef MOORE_SEQ_DET_CNT_EN
    check("midrst_hits", 32'(h_ov), 0);
`endif
    s4 = 4'b1011;
    for (int i = 0; i < 4; i++) step(s4[3-i], 1'b1);
    check("after_rst_match", 32'(m_ov), 1);
    check("after_rst_y", 32'(y_ov), 3);

    // Two-bit pattern 11
    do_reset();
    s4 = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      step(s4[3-i], 1'b1);
      check($sformatf("l2_y%0d", i + 1), 32'(y_l2), exp_y_l2[i]);
    end
`ifdef MOORE_SEQ_DET_CNT_EN
    check("l2_hits", 32'(h_l2), 2);

    // Counter saturation
    do_reset();
    s4 = 4'b1011;
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 4; i++) step(s4[3-i], 1'b1);
      if (r == 253) check("sat_254", 32'(h_no), 254);
      if (r == 254) check("sat_255", 32'(h_no), 255);
    end
    check("sat_hold", 32'(h_no), 255);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
